// File: rtl/bus_source_arbiter_pkg.sv
// Shared definitions for the bus source arbiter: default sizes, the transfer
// slot state, and the well-known source indices carried on bus_sel.
package bus_source_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_SRC_DEF    = 24;
    localparam int SEL_W_DEF      = $clog2(NUM_SRC_DEF);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bus_state_t;

    // Source indices as decoded by bus_sel consumers
    localparam logic [SEL_W_DEF-1:0] R0              = SEL_W_DEF'(0);
    localparam logic [SEL_W_DEF-1:0] R1              = SEL_W_DEF'(1);
    localparam logic [SEL_W_DEF-1:0] R2              = SEL_W_DEF'(2);
    localparam logic [SEL_W_DEF-1:0] R3              = SEL_W_DEF'(3);
    localparam logic [SEL_W_DEF-1:0] R4              = SEL_W_DEF'(4);
    localparam logic [SEL_W_DEF-1:0] R5              = SEL_W_DEF'(5);
    localparam logic [SEL_W_DEF-1:0] R6              = SEL_W_DEF'(6);
    localparam logic [SEL_W_DEF-1:0] R7              = SEL_W_DEF'(7);
    localparam logic [SEL_W_DEF-1:0] R8              = SEL_W_DEF'(8);
    localparam logic [SEL_W_DEF-1:0] R9              = SEL_W_DEF'(9);
    localparam logic [SEL_W_DEF-1:0] R10             = SEL_W_DEF'(10);
    localparam logic [SEL_W_DEF-1:0] R11             = SEL_W_DEF'(11);
    localparam logic [SEL_W_DEF-1:0] R12             = SEL_W_DEF'(12);
    localparam logic [SEL_W_DEF-1:0] R13             = SEL_W_DEF'(13);
    localparam logic [SEL_W_DEF-1:0] R14             = SEL_W_DEF'(14);
    localparam logic [SEL_W_DEF-1:0] R15             = SEL_W_DEF'(15);
    localparam logic [SEL_W_DEF-1:0] HI              = SEL_W_DEF'(16);
    localparam logic [SEL_W_DEF-1:0] LO              = SEL_W_DEF'(17);
    localparam logic [SEL_W_DEF-1:0] Zhigh           = SEL_W_DEF'(18);
    localparam logic [SEL_W_DEF-1:0] Zlow            = SEL_W_DEF'(19);
    localparam logic [SEL_W_DEF-1:0] PC              = SEL_W_DEF'(20);
    localparam logic [SEL_W_DEF-1:0] MDR             = SEL_W_DEF'(21);
    localparam logic [SEL_W_DEF-1:0] InPort          = SEL_W_DEF'(22);
    localparam logic [SEL_W_DEF-1:0] C_sign_extended = SEL_W_DEF'(23);

endpackage

// File: rtl/bus_source_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Rotates a doubled request vector down by ptr, then priority-encodes the lowest bit.
module rr_priority_pick #(
    parameter int NUM_SRC = 24,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               found
);

    logic [2*NUM_SRC-1:0] doubled;
    logic [NUM_SRC-1:0]   rotated;
    logic [SEL_W-1:0]     offset;
    logic [SEL_W:0]       sum;

    assign doubled = {req, req};
    assign rotated = doubled[ptr +: NUM_SRC];

    always_comb begin
        offset = '0;
        found  = |rotated;
        // Descending scan so the lowest set bit wins
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = SEL_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (SEL_W + 1)'(NUM_SRC)) begin
            sum = sum - (SEL_W + 1)'(NUM_SRC);
        end
        winner = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin bus source arbiter: captures one requesting source's word per
// transfer onto BusMuxOut with a valid/ready handshake and a one-cycle grant.
module bus_source_arbiter
    import bus_source_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int SEL_W      = $clog2(NUM_SRC)
) (
    input  logic                          clock,
    input  logic                          clear_n,
    input  logic [NUM_SRC-1:0]            src_req,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_grant,
    output logic [DATA_WIDTH-1:0]         BusMuxOut,
    output logic                          bus_valid,
    input  logic                          bus_ready,
    output logic [SEL_W-1:0]              bus_sel
);

    bus_state_t            state_reg, state_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [SEL_W-1:0]      sel_reg, sel_next;
    logic [NUM_SRC-1:0]    grant_reg, grant_next;
    logic [SEL_W-1:0]      rr_ptr_reg, rr_ptr_next;

    logic [DATA_WIDTH-1:0] src_words [NUM_SRC];
    logic [SEL_W-1:0]      winner;
    logic                  found;
    logic                  slot_free;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign src_words[gi] = src_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_priority_pick #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req    (src_req),
        .ptr    (rr_ptr_reg),
        .winner (winner),
        .found  (found)
    );

    assign slot_free = (state_reg == EMPTY) || bus_ready;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg  <= EMPTY;
            data_reg   <= '0;
            sel_reg    <= '0;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            data_reg   <= data_next;
            sel_reg    <= sel_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        data_next   = data_reg;
        sel_next    = sel_reg;
        grant_next  = '0;
        rr_ptr_next = rr_ptr_reg;
        if (slot_free) begin
            if (found) begin
                state_next  = FULL;
                data_next   = src_words[winner];
                sel_next    = winner;
                grant_next  = NUM_SRC'(1) << winner;
                rr_ptr_next = (winner == SEL_W'(NUM_SRC - 1)) ? '0 : winner + SEL_W'(1);
            end else begin
                // Word and index stay visible while idle
                state_next = EMPTY;
            end
        end
    end

    assign BusMuxOut = data_reg;
    assign bus_valid = (state_reg == FULL);
    assign bus_sel   = sel_reg;
    assign src_grant = grant_reg;

endmodule

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
- Drives the shared datapath bus (BusMuxOut) from up to NUM_SRC register/port sources. It is the transmit end that feeds the per-register bus-load registers.
- Each source raises a request. The block grants one source per transfer, round-robin, and registers that source's word onto BusMuxOut with a valid/ready handshake toward the sinks.
- It also outputs the encoded source index for debug and trace.

Parameters:
- DATA_WIDTH, 32, bus word width.
- NUM_SRC, 24, number of bus sources (2..32).
- SEL_W, $clog2(NUM_SRC), width of the encoded source index.

Ports:
- clock  in  1  sole clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- src_req  in  NUM_SRC  per-source request; a source holds it high until it sees its grant bit.
- src_data  in  NUM_SRC*DATA_WIDTH  flattened source words; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_grant  out  NUM_SRC  one-hot, single-cycle pulse to the source whose word was captured.
- BusMuxOut  out  DATA_WIDTH  registered bus word.
- bus_valid  out  1  BusMuxOut holds an untaken word.
- bus_ready  in  1  sink accepts the word this cycle.
- bus_sel  out  SEL_W  index of the source currently on the bus.

Behaviour:
- Reset (clear_n low, asynchronous) forces:
  - BusMuxOut = 0, bus_valid = 0, src_grant = 0, bus_sel = 0.
  - Round-robin pointer rr_ptr = 0.
  - Reset may assert mid-transfer; the in-flight word is discarded and no grant is issued.
- "Slot free" means bus_valid == 0, or bus_valid == 1 with bus_ready == 1 (same-cycle pass-through allowed).
- When the slot is free and src_req != 0, on the next rising edge:
  - Select the winner: first set bit of src_req at or after rr_ptr, searching upward and wrapping past NUM_SRC-1 to 0.
  - BusMuxOut <= src_data[winner], bus_sel <= winner, bus_valid <= 1.
  - src_grant <= one-hot(winner) for exactly one cycle.
  - rr_ptr <= winner+1, wrapping NUM_SRC-1 to 0.
- When the slot is free and src_req == 0:
  - bus_valid <= 0.
  - BusMuxOut and bus_sel hold their previous value; BusMuxOut is never zeroed outside reset.
- When bus_valid == 1 and bus_ready == 0:
  - BusMuxOut, bus_sel and bus_valid hold.
  - No grant is issued and rr_ptr holds; requests keep pending.
- Latency: request seen at edge k gives data on BusMuxOut and the grant at edge k+1. Sustained throughput is one word per cycle while bus_ready = 1.
- A source sees src_grant the cycle after capture. If it keeps req high in that grant cycle, the request is treated as a new request.
- Data is sampled only at the capture edge; later changes to src_data do not affect BusMuxOut.
- Requests at bit positions >= NUM_SRC do not exist; src_req width equals NUM_SRC exactly.
- State is two-phase, EMPTY and FULL, encoded by bus_valid:
  - EMPTY -> FULL on any request.
  - FULL -> EMPTY on bus_ready with no request.
  - FULL -> FULL on bus_ready with a request, or on !bus_ready.

Decomposition:
- Shared package holds:
  - bus width constant (DATA_WIDTH default 32).
  - NUM_SRC default.
  - source index constants (R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C_sign_extended) as SEL_W-wide localparams, used by bus_sel consumers.
- One sub-module: rr_priority_pick. It is combinational; from src_req and rr_ptr it outputs winner index and found flag, using a double-width rotate-and-priority-encode.

Test Plan:
1. Reset: clear_n low mid-stream with bus_valid=1 -> all outputs 0 immediately (asynchronous). After release with src_req=0 for 3 cycles -> bus_valid stays 0.
2. Single source: src_req[5]=1, src_data[5]=32'hDEADBEEF, bus_ready=1 -> next edge BusMuxOut=32'hDEADBEEF, bus_sel=5, src_grant=1<<5 for one cycle, rr_ptr=6.
3. Round-robin: src_req bits 2, 7, 20 held with bus_ready=1 from rr_ptr=0 -> grants in order 2, 7, 20, then 2 again, one per cycle.
4. Wrap-around: rr_ptr=23 (after granting 22), src_req={bit0, bit22} -> grant 0, then 22.
5. Backpressure: word from src 3 on bus, bus_ready=0 for 4 cycles while src 9 requests -> BusMuxOut, bus_sel=3 and bus_valid hold, no grant. bus_ready=1 -> same edge captures src 9.
6. Idle hold: after last transfer taken with src_req=0 -> bus_valid=0, BusMuxOut keeps the last word (e.g. 32'h00000042), bus_sel unchanged.
